// File: rtl/wait_state_memory.sv
// wait_state_memory: single-clock word memory with a 1-cycle fetch port and a wait-stated data port.
// Latency: fetch 1 cycle; data access WAIT_CYC+1 cycles from accept edge to data_ready pulse.
// Backpressure: data port accepts one request at a time; requests are ignored until the FSM returns to IDLE.
// Ports: clk/reset (async active-high); inst_addr/inst_req -> instr/inst_valid;
//        data_addr/data_in/mem_read/mem_write -> data_out/data_ready.
// Optional: define MEM_BYTE_WRITE_EN to add byte_en (DATA_W/8 bits) for per-byte write masking.
module wait_state_memory #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT_CYC   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_req,
    output logic [DATA_W-1:0]   instr,
    output logic                inst_valid,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                mem_read,
    input  logic                mem_write,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] byte_en,
`endif
    output logic [DATA_W-1:0]   data_out,
    output logic                data_ready
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    logic [DATA_W-1:0]     r_mem [DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;
    logic                  w_commit;

    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DATA_W-1:0]     r_wdat;
    logic [NB-1:0]         r_be;
    logic                  r_is_write;

    logic [DATA_W-1:0]     r_instr;
    logic                  r_inst_valid;
    logic [DATA_W-1:0]     r_data_out;
    logic                  r_data_ready;

    logic [DEPTH_LOG2-1:0] w_inst_idx;
    logic [DEPTH_LOG2-1:0] w_data_idx;
    logic [NB-1:0]         w_be;
    logic                  w_unused;

    // Upper address bits are dropped, so addresses alias modulo the depth.
    assign w_inst_idx = inst_addr[LSB+DEPTH_LOG2-1:LSB];
    assign w_data_idx = data_addr[LSB+DEPTH_LOG2-1:LSB];
    assign w_unused   = ^{inst_addr, data_addr};

`ifdef MEM_BYTE_WRITE_EN
    assign w_be = byte_en;
`else
    assign w_be = '1;
`endif

    assign instr      = r_instr;
    assign inst_valid = r_inst_valid;
    assign data_out   = r_data_out;
    assign data_ready = r_data_ready;

    // Fetch port: nonblocking read here and nonblocking write below give
    // read-before-write when a fetch and a write commit share an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr      <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= inst_req;
            if (inst_req) begin
                r_instr <= r_mem[w_inst_idx];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // Leave on the edge the counter hits zero; the zero test only guards a corrupted count.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= '0;
            r_wdat       <= '0;
            r_be         <= '0;
            r_is_write   <= 1'b0;
            r_data_out   <= '0;
            r_data_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_data_ready <= w_commit;
            if (w_accept) begin
                r_idx      <= w_data_idx;
                r_wdat     <= data_in;
                r_be       <= w_be;
                // Write wins when both strobes are high.
                r_is_write <= mem_write;
            end
            if (w_commit && !r_is_write) begin
                r_data_out <= r_mem[r_idx];
            end
        end
    end

    // Array is never reset; reset forces IDLE, so an aborted write never reaches commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write) begin
            for (int b = 0; b < NB; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][b*8 +: 8] <= r_wdat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// tb_wait_state_memory: checks wait_state_memory with a vector table, corner-case sequences and random traffic.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_wait_state_memory;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] inst_addr;
    logic        inst_req;
    logic [31:0] instr;
    logic        inst_valid;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        data_ready;

    logic [31:0] d0_instr;
    logic        d0_iv;
    logic [31:0] d0_addr;
    logic [31:0] d0_din;
    logic        d0_rd;
    logic        d0_wr;
    logic [31:0] d0_dout;
    logic        d0_ready;

`ifdef MEM_BYTE_WRITE_EN
    logic [3:0]  byte_en;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wait_state_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYC(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .inst_addr  (inst_addr),
        .inst_req   (inst_req),
        .instr      (instr),
        .inst_valid (inst_valid),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
`ifdef MEM_BYTE_WRITE_EN
        .byte_en    (byte_en),
`endif
        .data_out   (data_out),
        .data_ready (data_ready)
    );

    wait_state_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYC(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .inst_addr  (32'h0),
        .inst_req   (1'b0),
        .instr      (d0_instr),
        .inst_valid (d0_iv),
        .data_addr  (d0_addr),
        .data_in    (d0_din),
        .mem_read   (d0_rd),
        .mem_write  (d0_wr),
`ifdef MEM_BYTE_WRITE_EN
        .byte_en    (4'hF),
`endif
        .data_out   (d0_dout),
        .data_ready (d0_ready)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] mdl [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data-port transaction on the WAIT_CYC=2 instance; lat counts edges after the accept edge.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] dout, output int lat);
        data_addr = a;
        data_in   = d;
        mem_read  = rd;
        mem_write = wr;
        tick();
        // Scramble the inputs: the captured request must not follow them.
        mem_read  = 1'b0;
        mem_write = 1'b0;
        data_addr = $urandom;
        data_in   = $urandom;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (data_ready) break;
        end
        dout = data_out;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    initial begin
        logic [31:0] dout;
        logic [31:0] exp_dout;
        logic [31:0] exp_instr;
        int          lat;

        reset     = 1'b1;
        inst_addr = '0;
        inst_req  = 1'b0;
        data_addr = '0;
        data_in   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        d0_addr   = '0;
        d0_din    = '0;
        d0_rd     = 1'b0;
        d0_wr     = 1'b0;
`ifdef MEM_BYTE_WRITE_EN
        byte_en   = 4'hF;
`endif

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0BAD_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_07FC, 32'hFFFF_0000, 32'h0BAD_F00D};
        vecs[7] = '{1'b1, 1'b0, 32'h8000_03FC, 32'h0,         32'hFFFF_0000};

        // Reset state
        tick();
        tick();
        chk("rst instr", instr, 32'h0);
        chk("rst inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst data_out", data_out, 32'h0);
        chk("rst data_ready", {31'h0, data_ready}, 32'h0);
        chk("rst d0_instr", d0_instr, 32'h0);
        chk("rst d0_iv", {31'h0, d0_iv}, 32'h0);
        reset = 1'b0;
        tick();

        // Vector table: latency, read data, write leaves data_out alone, single-cycle pulse
        for (int v = 0; v < 8; v++) begin
            access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdat, dout, lat);
            chk($sformatf("vec%0d latency", v), lat, 32'd3);
            chk($sformatf("vec%0d data_out", v), dout, vecs[v].exp_dout);
            tick();
            chk($sformatf("vec%0d pulse end", v), {31'h0, data_ready}, 32'h0);
        end

        // Fetch, then reset in the middle of a write wait
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0020;
        tick();
        chk("fetch instr", instr, 32'h1234_5678);
        chk("fetch valid", {31'h0, inst_valid}, 32'h1);
        inst_req  = 1'b0;
        data_addr = 32'h0000_0010;
        data_in   = 32'hDEAD_BEEF;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("abort instr", instr, 32'h0);
        chk("abort data_out", data_out, 32'h0);
        chk("abort inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("abort data_ready", {31'h0, data_ready}, 32'h0);
        tick();
        reset = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, dout, lat);
        chk("abort reread latency", lat, 32'd3);
        chk("abort reread data", dout, 32'h0BAD_F00D);

        // Read+write together, with a same-edge fetch of that word at commit
        data_addr = 32'h0000_0020;
        data_in   = 32'h0000_0001;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0020;
        tick();
        chk("rw ready", {31'h0, data_ready}, 32'h1);
        chk("rw data_out held", data_out, 32'h0BAD_F00D);
        chk("rbw instr", instr, 32'h1234_5678);
        chk("rbw valid", {31'h0, inst_valid}, 32'h1);
        inst_req = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, dout, lat);
        chk("rw reread", dout, 32'h0000_0001);
        inst_req = 1'b1;
        tick();
        chk("rw refetch", instr, 32'h0000_0001);
        inst_req = 1'b0;
        tick();
        chk("fetch idle valid", {31'h0, inst_valid}, 32'h0);
        chk("fetch idle hold", instr, 32'h0000_0001);

`ifdef MEM_BYTE_WRITE_EN
        access(1'b0, 1'b1, 32'h0000_0040, 32'h0, dout, lat);
        byte_en = 4'b0010;
        access(1'b0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, dout, lat);
        byte_en = 4'hF;
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, dout, lat);
        chk("byte_en merge", dout, 32'h0000_FF00);
`endif

        // Zero-wait instance: init two words, then back-to-back reads
        d0_addr = 32'h0;
        d0_din  = 32'hC0FF_EE00;
        d0_wr   = 1'b1;
        tick();
        d0_wr = 1'b0;
        tick();
        chk("d0 wr0 ready", {31'h0, d0_ready}, 32'h1);
        d0_addr = 32'h4;
        d0_din  = 32'h0000_BEEF;
        d0_wr   = 1'b1;
        tick();
        d0_wr = 1'b0;
        tick();
        chk("d0 wr1 ready", {31'h0, d0_ready}, 32'h1);
        d0_addr = 32'h0;
        d0_rd   = 1'b1;
        tick();
        chk("d0 accept0 no ready", {31'h0, d0_ready}, 32'h0);
        d0_addr = 32'h4;
        tick();
        chk("d0 rd0 ready", {31'h0, d0_ready}, 32'h1);
        chk("d0 rd0 data", d0_dout, 32'hC0FF_EE00);
        tick();
        chk("d0 gap", {31'h0, d0_ready}, 32'h0);
        d0_rd = 1'b0;
        tick();
        chk("d0 rd1 ready", {31'h0, d0_ready}, 32'h1);
        chk("d0 rd1 data", d0_dout, 32'h0000_BEEF);
        tick();
        chk("d0 rd1 pulse end", {31'h0, d0_ready}, 32'h0);

        // Random data traffic over 16 words with random aliasing bits
        for (int w = 0; w < 16; w++) begin
            mdl[w] = $urandom;
            access(1'b0, 1'b1, 32'(w) << 2, mdl[w], dout, lat);
        end
        exp_dout = 32'h0000_0001;
        for (int n = 0; n < 150; n++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] d;
            op = int'($urandom_range(0, 2));
            a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            access(op != 1, op != 0, a, d, dout, lat);
            if (op == 0) exp_dout = mdl[widx(a)];
            else         mdl[widx(a)] = d;
            chk($sformatf("rand%0d latency", n), lat, 32'd3);
            chk($sformatf("rand%0d data_out", n), dout, exp_dout);
        end

        // Random fetch traffic against the same model
        exp_instr = instr;
        for (int n = 0; n < 100; n++) begin
            logic [31:0] a;
            logic        rq;
            rq = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            inst_req  = rq;
            inst_addr = a;
            tick();
            if (rq) exp_instr = mdl[widx(a)];
            chk($sformatf("fetch%0d valid", n), {31'h0, inst_valid}, {31'h0, rq});
            chk($sformatf("fetch%0d instr", n), instr, exp_instr);
        end
        inst_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
